// File: rtl/cfg_issuer_pkg.sv
// Shared definitions for the configuration issuer: default field widths,
// the packed configuration set and the issue FSM state encoding.
package cfg_issuer_pkg;

  localparam int DEF_DATA_CWIDTH = 32;
  localparam int DEF_WICP_CWIDTH = 32;
  localparam int DEF_TMPC_CWIDTH = 32;
  localparam int DEF_POST_CWIDTH = 16;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_ACK_TIMEOUT = 8;

  typedef struct packed {
    logic [DEF_DATA_CWIDTH-1:0] data;
    logic [DEF_WICP_CWIDTH-1:0] wicp;
    logic [DEF_TMPC_CWIDTH-1:0] tmpc;
    logic [DEF_POST_CWIDTH-1:0] post;
  } cfg_set_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/cfg_issuer_if.sv
// Host push port plus target cfg port of the issuer, bundled as one interface.
// master is the issuer's view, slave is the surrounding host/target view.
interface cfg_issuer_if
  import cfg_issuer_pkg::*;
#(
  parameter int DATA_CWIDTH = DEF_DATA_CWIDTH,
  parameter int WICP_CWIDTH = DEF_WICP_CWIDTH,
  parameter int TMPC_CWIDTH = DEF_TMPC_CWIDTH,
  parameter int POST_CWIDTH = DEF_POST_CWIDTH,
  parameter int DEPTH       = DEF_DEPTH
);

  logic                     push_valid;
  logic                     push_ready;
  logic [DATA_CWIDTH-1:0]   push_data;
  logic [WICP_CWIDTH-1:0]   push_wicp;
  logic [TMPC_CWIDTH-1:0]   push_tmpc;
  logic [POST_CWIDTH-1:0]   push_post;

  logic                     cfg_valid;
  logic                     cfg_busy;
  logic [DATA_CWIDTH-1:0]   cfg_data_data;
  logic [WICP_CWIDTH-1:0]   cfg_wicp_data;
  logic [TMPC_CWIDTH-1:0]   cfg_tmpc_data;
  logic [POST_CWIDTH-1:0]   cfg_post_data;

  logic                     issue_done;
  logic [$clog2(DEPTH):0]   pending;
  logic                     timeout_err;

  modport master (
    input  push_valid, push_data, push_wicp, push_tmpc, push_post, cfg_busy,
    output push_ready, cfg_valid, cfg_data_data, cfg_wicp_data, cfg_tmpc_data,
           cfg_post_data, issue_done, pending, timeout_err
  );

  modport slave (
    output push_valid, push_data, push_wicp, push_tmpc, push_post, cfg_busy,
    input  push_ready, cfg_valid, cfg_data_data, cfg_wicp_data, cfg_tmpc_data,
           cfg_post_data, issue_done, pending, timeout_err
  );

endinterface

// File: rtl/cfg_issuer_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered occupancy count.
// The head entry is visible combinationally so the consumer can load it on pop.
module cfg_issuer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      count_r;
  logic             full_s;
  logic             empty_s;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // Overflow/underflow are blocked here as well, independent of the caller.
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign wr_ok_s = wr_en && !full_s;
  assign rd_ok_s = rd_en && !empty_s;
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
  assign count   = count_r;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + PTR_ONE;
        2'b01:   count_r <= count_r - PTR_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cfg_issuer.sv
// Configuration issuer: buffers complete config sets and hands them to the
// array one at a time over the cfg_valid / cfg_busy handshake.
module cfg_issuer
  import cfg_issuer_pkg::*;
#(
  parameter int DATA_CWIDTH = DEF_DATA_CWIDTH,
  parameter int WICP_CWIDTH = DEF_WICP_CWIDTH,
  parameter int TMPC_CWIDTH = DEF_TMPC_CWIDTH,
  parameter int POST_CWIDTH = DEF_POST_CWIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  cfg_issuer_if.master bus
);

  localparam int SET_W    = DATA_CWIDTH + WICP_CWIDTH + TMPC_CWIDTH + POST_CWIDTH;
  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int TMPC_LSB = POST_CWIDTH;
  localparam int WICP_LSB = TMPC_LSB + TMPC_CWIDTH;
  localparam int DATA_LSB = WICP_LSB + WICP_CWIDTH;
  localparam int ACK_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [ACK_W-1:0] ACK_ONE  = ACK_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE      = 2'(ST_IDLE);
  localparam logic [1:0] S_ISSUE     = 2'(ST_ISSUE);
  localparam logic [1:0] S_WAIT_ACK  = 2'(ST_WAIT_ACK);
  localparam logic [1:0] S_WAIT_DONE = 2'(ST_WAIT_DONE);

  logic [1:0]             state_r;
  logic [1:0]             state_nxt_s;
  logic [ACK_W-1:0]       ack_cnt_r;
  logic [SET_W-1:0]       push_set_s;
  logic [SET_W-1:0]       head_s;
  logic [CNT_W-1:0]       count_s;
  logic                   push_fire_s;
  logic                   pop_s;
  logic                   done_s;
  logic                   ack_timeout_s;
  logic                   cfg_valid_r;
  logic                   issue_done_r;
  logic                   timeout_err_r;
  logic [DATA_CWIDTH-1:0] data_r;
  logic [WICP_CWIDTH-1:0] wicp_r;
  logic [TMPC_CWIDTH-1:0] tmpc_r;
  logic [POST_CWIDTH-1:0] post_r;

  // Readiness comes from the registered count only, so a pop on the same
  // edge never lets a push into a full buffer.
  assign push_fire_s = bus.push_valid && (count_s != CNT_FULL);
  assign push_set_s  = {bus.push_data, bus.push_wicp, bus.push_tmpc, bus.push_post};

  cfg_issuer_fifo #(
    .WIDTH (SET_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_fire_s),
    .wr_data (push_set_s),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .count   (count_s)
  );

  // Next-state logic; the pop happens on the edge that enters ISSUE.
  always_comb begin
    state_nxt_s   = state_r;
    pop_s         = 1'b0;
    done_s        = 1'b0;
    ack_timeout_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if ((count_s != {CNT_W{1'b0}}) && !bus.cfg_busy) begin
          state_nxt_s = S_ISSUE;
          pop_s       = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_nxt_s = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.cfg_busy) begin
          state_nxt_s = S_WAIT_DONE;
        end else if (ack_cnt_r == ACK_LAST) begin
          // Busy never rose: treat the set as completed instantly.
          state_nxt_s   = S_IDLE;
          done_s        = 1'b1;
          ack_timeout_s = 1'b1;
        end else begin
          state_nxt_s = S_WAIT_ACK;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.cfg_busy) begin
          state_nxt_s = S_IDLE;
          done_s      = 1'b1;
        end else begin
          state_nxt_s = S_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // FSM state, ack counter and status strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      ack_cnt_r     <= {ACK_W{1'b0}};
      cfg_valid_r   <= 1'b0;
      issue_done_r  <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cfg_valid_r  <= pop_s;
      issue_done_r <= done_s;
      if (ack_timeout_s) begin
        timeout_err_r <= 1'b1;
      end
      if (state_r == S_ISSUE) begin
        ack_cnt_r <= {ACK_W{1'b0}};
      end else if (state_r == S_WAIT_ACK) begin
        ack_cnt_r <= ack_cnt_r + ACK_ONE;
      end else begin
        ack_cnt_r <= ack_cnt_r;
      end
    end
  end

  // Issued fields load with the head set on ISSUE entry and hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= {DATA_CWIDTH{1'b0}};
      wicp_r <= {WICP_CWIDTH{1'b0}};
      tmpc_r <= {TMPC_CWIDTH{1'b0}};
      post_r <= {POST_CWIDTH{1'b0}};
    end else if (pop_s) begin
      data_r <= head_s[DATA_LSB +: DATA_CWIDTH];
      wicp_r <= head_s[WICP_LSB +: WICP_CWIDTH];
      tmpc_r <= head_s[TMPC_LSB +: TMPC_CWIDTH];
      post_r <= head_s[0 +: POST_CWIDTH];
    end
  end

  assign bus.push_ready    = (count_s != CNT_FULL);
  assign bus.pending       = count_s;
  assign bus.cfg_valid     = cfg_valid_r;
  assign bus.issue_done    = issue_done_r;
  assign bus.timeout_err   = timeout_err_r;
  assign bus.cfg_data_data = data_r;
  assign bus.cfg_wicp_data = wicp_r;
  assign bus.cfg_tmpc_data = tmpc_r;
  assign bus.cfg_post_data = post_r;

endmodule

// File: doc/cfg_issuer.md
# cfg_issuer

Configuration transmitter for the accelerator's cfg port: buffers complete configuration sets (data, WICP, TMPC and post-processing fields) pushed by the host/controller side. It issues them one at a time over the `cfg_valid`/`cfg_busy` handshake that the generated top-level accepts. It sits between the host register/DMA front end and the array top, one instance per array.

## Interface
- `DATA_CWIDTH`, 32: width of the data-path config field
- `WICP_CWIDTH`, 32: width of the weight/input/channel-partition config field
- `TMPC_CWIDTH`, 32: width of the temporal-control config field
- `POST_CWIDTH`, 16: width of the post-processing config field
- `DEPTH`, 4: config sets buffered; power of two, ≥2
- `ACK_TIMEOUT`, 8: cycles to wait for `cfg_busy` to rise after issue; ≥1

Ports:
- `clk` in 1: the single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `push_valid` in 1: a config set is presented
- `push_ready` out 1: buffer can accept; transfer on `push_valid && push_ready`
- `push_data` / `push_wicp` / `push_tmpc` / `push_post` in `*_CWIDTH`: fields of the set
- `cfg_valid` out 1: one-cycle issue strobe to target
- `cfg_busy` in 1: target is processing a config
- `cfg_data_data` / `cfg_wicp_data` / `cfg_tmpc_data` / `cfg_post_data` out `*_CWIDTH`: issued fields
- `issue_done` out 1: one-cycle pulse when the target finishes a set
- `pending` out `$clog2(DEPTH)+1`: sets buffered, not yet issued
- `timeout_err` out 1: sticky; a set was issued and `cfg_busy` never rose within `ACK_TIMEOUT`

## Operation
- Buffer: FIFO of `DEPTH` packed sets, in push order. `push_ready = (pending != DEPTH)`, derived from registered count only. A push offered while full is not taken, even if a pop happens the same cycle. Push and pop in one cycle: count unchanged, both take effect.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - IDLE → ISSUE when `pending != 0 && !cfg_busy`.
  - ISSUE, exactly one cycle: `cfg_valid=1`. The head set drives the `cfg_*_data` outputs and is popped. → WAIT_ACK; the ack counter is cleared.
  - WAIT_ACK: `cfg_busy=1` → WAIT_DONE.
  - WAIT_ACK timeout: counter reaches `ACK_TIMEOUT-1` with `cfg_busy=0`. The target completed instantly: set `timeout_err`, pulse `issue_done`, → IDLE.
  - WAIT_DONE: `cfg_busy=0` → IDLE with `issue_done` pulsed that cycle.
- Only one set is outstanding at a time; no issue while `cfg_busy=1` in IDLE.
- `cfg_*_data` outputs are registered. They load only on entry to ISSUE and hold the last issued set afterwards.
- `timeout_err` clears only on `rst`.

## Timing
- Reset: FSM=IDLE, FIFO empty.
  - Outputs 0: `pending`, `cfg_valid`, all `cfg_*_data`, `issue_done`, `timeout_err`.
  - `push_ready=1`.
- Reset mid-operation: buffered sets are discarded. `cfg_valid` is low the cycle after `rst` is sampled. The target is not notified.
- Latency: a push accepted at edge t, into an empty buffer with FSM idle and `cfg_busy=0`: `pending=1` after t, `cfg_valid=1` in cycle t+2 (after edge t+1).
- `pending` decrements at the edge that enters ISSUE.
- Back-to-back sets: `issue_done` cycle N is IDLE. The next `cfg_valid` comes no earlier than cycle N+1, if `cfg_busy=0` in N.
- `issue_done` and `cfg_valid` are never high in the same cycle.

## Structure
- The shared cfg package holds the `cfg_set_t` packed struct (data, wicp, tmpc, post), the FSM state enum, and the default widths.
- Sub-module `cfg_issuer_fifo`: synchronous single-clock FIFO.
  - Parameters: width, depth.
  - Pointers with wrap bit; registered count; no first-word fall-through on outputs.
  - Head readable combinationally for the ISSUE load.
- Top: FSM, ack counter, output registers.

## Test plan
- Reset, then 1 push (data=0x11, wicp=0x22, tmpc=0x33, post=0x44), `cfg_busy` idle. Required:
  - `cfg_valid` pulses in cycle t+2 with those fields.
  - The target model raises busy 1 cycle later for 5 cycles.
  - `issue_done` fires the cycle busy falls; `pending` is 1→0.
- Push 5 sets back-to-back with `DEPTH=4` and `cfg_busy` held 1. Required:
  - `push_ready` drops after the 4th push; the 5th waits.
  - `pending=4`; no `cfg_valid` until busy drops.
  - Sets issue in push order.
- Target never raises busy. Required:
  - After issue, `issue_done` pulses at the 8th WAIT_ACK cycle.
  - `timeout_err=1` and stays set across the next normal issue.
- Full buffer with simultaneous pop and push on the ISSUE edge. Required:
  - The push is refused that cycle.
  - `pending` goes 4→3, then 4 on the retried push.
- Assert `rst` during WAIT_DONE with 2 sets pending. Required:
  - Next cycle: `pending=0`, `cfg_*_data=0`, FSM IDLE.
  - No `cfg_valid` while busy persists.
- Busy is already high when the first set arrives. Required:
  - Issue is held in IDLE.
  - `cfg_valid` comes exactly 1 cycle after busy is sampled low.
